// File: rtl/led_chaser.sv
// rtl/led_chaser.sv - programmable tick divider driving a rotate/bounce/fill/hold LED pattern sequencer
// Optional manual single-step input enabled by defining LED_CHASER_STEP_EN.
module led_chaser #(
  parameter int          WIDTH       = 10,
  parameter int          DIV_W       = 27,
  parameter int unsigned DIV_DEFAULT = 12444444
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             dir,
  input  logic             load_div,
  input  logic [DIV_W-1:0] div_value,
`ifdef LED_CHASER_STEP_EN
  input  logic             step,
`endif
  output logic             tick,
  output logic [WIDTH-1:0] leds,
  output logic             wrap
);

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_DEFAULT);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [DIV_W-1:0] div_reg;
  logic [DIV_W-1:0] cnt;
  logic             bounce_up;
  logic [1:0]       mode_q;

  logic [WIDTH-1:0] step_leds;
  logic             step_up;
  logic             step_wrap;
  logic             one_hot;
  logic             manual;
  logic             fire;
  logic             mode_change;

`ifdef LED_CHASER_STEP_EN
  assign manual = step & ~enable;
`else
  assign manual = 1'b0;
`endif

  assign fire        = (enable && (cnt == '0)) || manual;
  assign mode_change = (mode != mode_q);

  // Next pattern for one step; the registered mode is used so a mode
  // change always restarts cleanly before the new mode steps.
  always_comb begin
    step_leds = leds;
    step_up   = bounce_up;
    step_wrap = 1'b0;
    one_hot   = (leds != '0) && ((leds & (leds - ONE)) == '0);
    case (mode_q)
      2'd0: begin
        if (!dir) begin
          step_leds = {leds[WIDTH-2:0], leds[WIDTH-1]};
          step_wrap = leds[WIDTH-1];
        end else begin
          step_leds = {leds[0], leds[WIDTH-1:1]};
          step_wrap = leds[0];
        end
      end
      2'd1: begin
        if (!one_hot) begin
          step_leds = ONE;
          step_up   = 1'b1;
        end else if (bounce_up) begin
          if (leds[WIDTH-1]) begin
            step_leds = leds >> 1;
            step_up   = 1'b0;
          end else begin
            step_leds = leds << 1;
            step_up   = ~leds[WIDTH-2];
          end
        end else begin
          if (leds[0]) begin
            step_leds = leds << 1;
            step_up   = 1'b1;
          end else begin
            step_leds = leds >> 1;
            if (leds[1]) begin
              step_up   = 1'b1;
              step_wrap = 1'b1;
            end
          end
        end
      end
      2'd2: begin
        if (&leds) begin
          step_leds = '0;
          step_wrap = 1'b1;
        end else begin
          step_leds = {leds[WIDTH-2:0], 1'b1};
        end
      end
      default: begin
        step_leds = leds;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_reg   <= DIV_INIT;
      cnt       <= DIV_INIT;
      leds      <= ONE;
      bounce_up <= 1'b1;
      mode_q    <= mode;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (load_div) begin
        div_reg <= div_value;
      end
      if (mode_change) begin
        leds      <= ONE;
        bounce_up <= 1'b1;
        mode_q    <= mode;
        cnt       <= load_div ? div_value : div_reg;
      end else if (load_div) begin
        cnt <= div_value;
      end else if (fire) begin
        cnt       <= div_reg;
        tick      <= 1'b1;
        wrap      <= step_wrap;
        leds      <= step_leds;
        bounce_up <= step_up;
      end else if (enable) begin
        cnt <= cnt - DIV_W'(1);
      end
    end
  end

endmodule

// File: doc/led_chaser.md
Name: led_chaser

Overview:
- Parametrised tick generator and LED pattern sequencer. Generalises the fixed 2 Hz divider and the single-bit LEDR shifter.
- Adds a runtime-programmable period, pattern width, four pattern modes, a direction control and a wrap pulse.
- Sits between CLOCK_50 and the LEDR bank. Its tick output can also pace other game logic, e.g. passive income.

Parameters:
WIDTH, 10, number of pattern bits (LEDs); must be >= 2
DIV_W, 27, divider counter width
DIV_DEFAULT, 12444444, reload value after reset; tick period = reload+1 cycles

Ports:
CLOCK_50  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
enable  input  1  1 = divider runs; 0 = divider and pattern hold
mode  input  2  0 rotate, 1 bounce, 2 fill bar, 3 hold
dir  input  1  rotate direction: 0 toward MSB, 1 toward LSB
load_div  input  1  1-cycle strobe; capture div_value
div_value  input  DIV_W  new reload value
tick  output  1  registered 1-cycle pulse, once per period
leds  output  WIDTH  current pattern
wrap  output  1  registered 1-cycle pulse when pattern completes a cycle

Behaviour:
- Reset (priority over everything):
  - div_reg=DIV_DEFAULT, cnt=DIV_DEFAULT, leds=1 (bit0 only).
  - bounce_up=1, mode_q=mode, tick=0, wrap=0.
- Registers:
  - div_reg: reload value.
  - cnt: down-counter.
  - bounce_up: bounce direction flag.
  - mode_q: mode seen last cycle.
- Divider (priority order):
  1. load_div=1: div_reg<=div_value, cnt<=div_value, tick<=0 that cycle; load_div has effect even when enable=0.
  2. Else enable=0: cnt, leds and bounce_up hold; tick=0, wrap=0.
  3. Else cnt==0: cnt<=div_reg, tick<=1, apply one pattern step.
  4. Else cnt<=cnt-1, tick<=0.
- Timing:
  - Period is div_reg+1 cycles.
  - div_value=0 gives a tick every enabled cycle.
  - leds and wrap update on the same edge at which tick goes high.
- Mode change (mode!=mode_q, not in reset):
  - leds<=1, bounce_up<=1, cnt<=div_reg, tick<=0, wrap<=0.
  - mode_q<=mode.
  - Takes priority over a coincident step. load_div still applies div_reg in the same cycle.
- Pattern step per mode:
  - Rotate (0), dir=0: leds<={leds[W-2:0],leds[W-1]}; wrap=old leds[W-1].
  - Rotate (0), dir=1: leds<={leds[0],leds[W-1:1]}; wrap=old leds[0].
  - Rotate mode rotates any pattern, including non-one-hot ones.
  - Bounce (1): if leds is not one-hot, leds<=1, bounce_up<=1, wrap=0.
  - Bounce, bounce_up=1: shift toward MSB. On reaching bit W-1, set bounce_up=0.
  - Bounce, bounce_up=0: shift toward LSB. On reaching bit 0, set bounce_up=1 and wrap=1.
  - Bounce has no dwell at the ends; sequence for W=4: 1,2,4,8,4,2,1,2... and dir is ignored.
  - Fill (2): all ones -> all zeros, with wrap=1.
  - Fill, otherwise: leds<={leds[W-2:0],1'b1}. From zero the next value is 0..01.
  - Hold (3): leds unchanged; tick still pulses; wrap=0.
- Output rules:
  - wrap is only ever asserted together with tick.
  - Both tick and wrap are 0 in any cycle without a step.
- Reset mid-period discards any partial count.

Optional Feature:
- Macro LED_CHASER_STEP_EN.
- When defined:
  - Adds input step (1 bit).
  - step=1 with enable=0 performs one pattern step and pulses tick (and wrap if applicable) on that edge.
  - cnt is reloaded to div_reg.
  - step is ignored while enable=1, and loses to reset, load_div and a mode change.
- When undefined: no step port; pattern advances only from the divider.

Test Plan:
- Reset timing: DIV_DEFAULT=3, WIDTH=4, mode=0, dir=0, enable=1, release reset -> tick every 4 cycles; leds 1,2,4,8,1. wrap=1 exactly with the 8->1 tick.
- Bounce: mode=1, W=4, div 0 -> leds 1,2,4,8,4,2,1 on consecutive cycles. wrap only on the 2->1 step; dir toggling has no effect.
- Fill: mode=2, W=4 -> leds 1,3,7,F,0,1. wrap on F->0; hold mode 3 keeps leds constant while tick still pulses.
- Divider load: load_div=1 with div_value=5 in the same cycle cnt==0 -> no tick that cycle; next tick 6 cycles later. enable=0 for 10 cycles freezes cnt and leds with tick=0.
- Mode change and reset: switch mode 0->1 while leds=4 -> next edge leds=1, tick=0, counter restarts. reset asserted mid-period -> leds=1, cnt=DIV_DEFAULT, tick=0 on next edge, overriding a coincident load_div.
- Step feature: with LED_CHASER_STEP_EN, enable=0, three step pulses -> three ticks, leds 1->2->4->8. With enable=1, step is ignored.
